// File: rtl/ofdm_rx_pkg.sv
// Shared constants for the OFDM RX sync path.
//   MAG_W            width of squared-magnitude samples (unsigned Q4.12 + spare MSB)
//   FRAC_BITS        fractional bits of the magnitude Q-format
//   DEF_MAX_LOG2_WIN default log2 of the largest energy window
package ofdm_rx_pkg;

  localparam int unsigned MAG_W            = 17;
  localparam int unsigned FRAC_BITS        = 12;
  localparam int unsigned DEF_MAX_LOG2_WIN = 6;

  // Limit a requested window exponent to the largest supported one.
  function automatic int unsigned clamp_log2(input int unsigned v, input int unsigned max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/energy_delay_line.sv
// Circular sample store returning the sample written N accepted samples ago.
//   clk_i       clock
//   rst_ni      asynchronous active-low reset (write pointer only)
//   wr_en_i     accept wr_data_i this cycle; advances the write pointer
//   wr_data_i   sample to store
//   win_log2_i  log2 of N for the read offset, must be <= AddrW
//   rd_data_o   registered read of mem[wr_ptr - N], taken on the write cycle
module energy_delay_line
  import ofdm_rx_pkg::*;
#(
  parameter int unsigned Width = MAG_W,
  parameter int unsigned AddrW = DEF_MAX_LOG2_WIN,
  parameter int unsigned LW    = $clog2(DEF_MAX_LOG2_WIN + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic [LW-1:0]    win_log2_i,
  output logic [Width-1:0] rd_data_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q;
  logic [AddrW-1:0] rd_addr;
  logic [Width-1:0] rd_data_q;

  // 1 << AddrW wraps to 0 in AddrW bits, so the full-depth window reads the slot
  // being overwritten; the non-blocking read below returns its old content.
  always_comb begin
    rd_addr = wr_ptr_q - (AddrW'(1) << win_log2_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
    end else if (wr_en_i) begin
      wr_ptr_q <= wr_ptr_q + AddrW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
      rd_data_q       <= mem_q[rd_addr];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sliding_window_energy_acc.sv
// Sliding-window energy accumulator: sum of the last N = 2**WinLog2 accepted squared
// magnitudes, with mean output, window-full flag and synchronous frame Clear.
// Three pipeline stages (capture / diff / accumulate): sample in cycle n -> output n+3.
//   Clk               clock
//   Rst_n             asynchronous active-low reset
//   Clear             sync restart: empty window, latch WinLog2
//   WinLog2           window exponent, sampled only with Clear, clamped to MAX_LOG2_WIN
//   InputEnable       DataInMagnituder valid this cycle
//   DataInMagnituder  unsigned squared magnitude
//   OutputEnable      result valid this cycle
//   SumMagnituder     sum of the last N accepted samples (holds between results)
//   MeanMagnituder    SumMagnituder >> latched WinLog2
//   WindowFull        sum covers N samples
module sliding_window_energy_acc
  import ofdm_rx_pkg::*;
#(
  parameter int unsigned IN_W         = MAG_W,
  parameter int unsigned MAX_LOG2_WIN = DEF_MAX_LOG2_WIN,
  parameter int unsigned LW           = $clog2(MAX_LOG2_WIN + 1),
  parameter int unsigned SUM_W        = IN_W + MAX_LOG2_WIN
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Clear,
  input  logic [LW-1:0]    WinLog2,
  input  logic             InputEnable,
  input  logic [IN_W-1:0]  DataInMagnituder,
  output logic             OutputEnable,
  output logic [SUM_W-1:0] SumMagnituder,
  output logic [IN_W-1:0]  MeanMagnituder,
  output logic             WindowFull
);

  localparam int unsigned CntW  = MAX_LOG2_WIN + 1;
  localparam int unsigned DiffW = SUM_W + 1;

  // Window control
  logic [LW-1:0]   win_q, win_sel;
  logic [CntW-1:0] win_len, fill_q, fill_d, fill_eff;
  logic            old_vld, full_now;

  // Stage 1: captured sample
  logic            s1_vld_q, s1_old_vld_q, s1_full_q;
  logic [IN_W-1:0] s1_data_q;
  logic [IN_W-1:0] old_data;

  // Stage 2: signed sum delta
  logic                    s2_vld_q, s2_full_q;
  logic signed [DiffW-1:0] diff_d, s2_diff_q;

  // Stage 3: accumulator and outputs
  logic                    oe_q, full_q;
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic [IN_W-1:0]         mean_q, mean_d;
  logic signed [DiffW-1:0] sum_ext;

  // A sample arriving together with Clear belongs to the new window, so it sees the
  // freshly selected length and an empty fill count.
  always_comb begin
    win_sel  = Clear ? LW'(clamp_log2(32'(WinLog2), MAX_LOG2_WIN)) : win_q;
    win_len  = CntW'(1) << win_sel;
    fill_eff = Clear ? '0 : fill_q;
    old_vld  = (fill_eff == win_len);
    full_now = ((fill_eff + CntW'(1)) >= win_len);
    fill_d   = fill_eff;
    if (InputEnable && !old_vld) begin
      fill_d = fill_eff + CntW'(1);
    end
  end

  energy_delay_line #(
    .Width (IN_W),
    .AddrW (MAX_LOG2_WIN),
    .LW    (LW)
  ) u_delay_line (
    .clk_i      (Clk),
    .rst_ni     (Rst_n),
    .wr_en_i    (InputEnable),
    .wr_data_i  (DataInMagnituder),
    .win_log2_i (win_sel),
    .rd_data_o  (old_data)
  );

  // Delay-line contents are ignored until the window has been refilled since
  // reset/Clear, so stale samples never leave the sum.
  always_comb begin
    diff_d = DiffW'(s1_data_q) - (s1_old_vld_q ? DiffW'(old_data) : DiffW'(0));
  end

  // The true sum is always within [0, N*(2**IN_W-1)], so truncating the signed
  // intermediate back to SUM_W is exact.
  always_comb begin
    sum_ext = DiffW'(sum_q) + s2_diff_q;
    sum_d   = sum_q;
    if (Clear) begin
      sum_d = '0;
    end else if (s2_vld_q) begin
      sum_d = SUM_W'(sum_ext);
    end
    mean_d = IN_W'(sum_d >> win_q);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      win_q        <= LW'(MAX_LOG2_WIN);
      fill_q       <= '0;
      s1_vld_q     <= 1'b0;
      s1_old_vld_q <= 1'b0;
      s1_full_q    <= 1'b0;
      s1_data_q    <= '0;
      s2_vld_q     <= 1'b0;
      s2_full_q    <= 1'b0;
      s2_diff_q    <= '0;
      oe_q         <= 1'b0;
      full_q       <= 1'b0;
      sum_q        <= '0;
      mean_q       <= '0;
    end else begin
      win_q  <= win_sel;
      fill_q <= fill_d;

      s1_vld_q <= InputEnable;
      if (InputEnable) begin
        s1_data_q    <= DataInMagnituder;
        s1_old_vld_q <= old_vld;
        s1_full_q    <= full_now;
      end

      // Clear discards everything already past capture.
      s2_vld_q <= s1_vld_q && !Clear;
      if (s1_vld_q) begin
        s2_diff_q <= diff_d;
        s2_full_q <= s1_full_q;
      end

      oe_q   <= s2_vld_q && !Clear;
      sum_q  <= sum_d;
      mean_q <= Clear ? '0 : mean_d;
      if (Clear) begin
        full_q <= 1'b0;
      end else if (s2_vld_q) begin
        full_q <= s2_full_q;
      end
    end
  end

  assign OutputEnable   = oe_q;
  assign SumMagnituder  = sum_q;
  assign MeanMagnituder = mean_q;
  assign WindowFull     = full_q;

endmodule
